// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter sharing one FIFO write port among N
// valid/ready requesters. A grant is held for a whole burst, ending on the
// owner's last beat or after MAX_BURST beats. Writes are gated by wr_full.
module fifo_wr_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IdW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [N-1:0]       req_val,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_rdy,
  output logic               wr_en,
  output logic [WIDTH-1:0]   wr_data,
  input  logic               wr_full,
  output logic [IdW-1:0]     grant_id,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e          state_q;
  logic [IdW-1:0]  owner_q;
  logic [IdW-1:0]  rr_ptr_q;
  logic [CntW-1:0] beat_cnt_q;
  logic            busy_q;

  logic            any_val;
  logic [IdW-1:0]  winner;
  int unsigned     idx;
  logic [IdW-1:0]  idx_w;
  logic            accept;
  logic            end_beat;
  logic [IdW-1:0]  rr_next;

  // Pick the first valid requester at or above rr_ptr, wrapping modulo N.
  always_comb begin
    any_val = 1'b0;
    winner  = '0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx   = (32'(rr_ptr_q) + i) % N;
      idx_w = IdW'(idx);
      if (!any_val && req_val[idx_w]) begin
        any_val = 1'b1;
        winner  = idx_w;
      end
    end
  end

  // Ready, accept and write data: only the owner is ever ready, and full blocks it at once.
  always_comb begin
    req_rdy = '0;
    accept  = 1'b0;
    wr_data = '0;
    if (state_q == StLock) begin
      req_rdy[owner_q] = ~wr_full;
      accept           = req_val[owner_q] & ~wr_full;
      if (accept) begin
        wr_data = req_data[32'(owner_q) * WIDTH +: WIDTH];
      end
    end
  end

  // Burst termination and the pointer that follows the current owner.
  always_comb begin
    end_beat = accept & (req_last[owner_q] | (beat_cnt_q == CntW'(MAX_BURST - 1)));
    rr_next  = (owner_q == IdW'(N - 1)) ? '0 : owner_q + 1'b1;
  end

  assign wr_en    = accept;
  assign grant_id = owner_q;
  assign busy     = busy_q;

  // Arbitration FSM; a missing valid from the owner holds the lock indefinitely.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StArb;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (any_val) begin
            owner_q    <= winner;
            beat_cnt_q <= '0;
            state_q    <= StLock;
            busy_q     <= 1'b1;
          end
        end
        StLock: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (end_beat) begin
              state_q  <= StArb;
              rr_ptr_q <= rr_next;
              busy_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StArb;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a behavioural FIFO model (DEPTH 8).
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic [N-1:0]     req_val = '0;
  logic [N*WIDTH-1:0] req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_rdy;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_full;
  logic [1:0]       grant_id;
  logic             busy;

  fifo_wr_arb #(.N(N), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .req_val  (req_val),
    .req_data (req_data),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // FIFO model and write/read logs
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] wr_log[$];
  logic [WIDTH-1:0] rd_log[$];
  logic fifo_full = 1'b0;
  logic rd_en = 1'b0;
  int   viol = 0;
  assign wr_full = fifo_full;

  always @(posedge clk) begin
    if (!rstb) begin
      fq.delete();
      fifo_full <= 1'b0;
    end else begin
      if (wr_en && wr_full) viol++;
      if (rd_en && fq.size() > 0) rd_log.push_back(fq.pop_front());
      if (wr_en) begin
        fq.push_back(wr_data);
        wr_log.push_back(wr_data);
      end
      fifo_full <= (fq.size() >= DEPTH);
    end
  end

  // Requester driver state
  int           cnt[N];
  int           rem[N];
  logic [N-1:0] active = '0;
  logic [N-1:0] hold = '0;
  logic [N-1:0] use_last = '0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_val[i]  = active[i] & ~hold[i];
      req_last[i] = use_last[i] && (rem[i] == 1);
      req_data[i*WIDTH +: WIDTH] = {4'(i), 4'(cnt[i])};
    end
  endtask

  // One clock: record handshakes before the edge, advance sources after it.
  task automatic cycle();
    logic [N-1:0] acc;
    #1;
    acc = req_val & req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        cnt[i]++;
        if (rem[i] > 0) rem[i]--;
        if (rem[i] == 0) active[i] = 1'b0;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    rd_en = 1'b0;
    active = '0;
    hold = '0;
    use_last = '0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      rem[i] = -1;
    end
    apply();
    @(posedge clk);
    @(posedge clk);
    #1;
    wr_log.delete();
    rd_log.delete();
    viol = 0;
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      rem[i] = -1;
    end
    active = 4'b1111;
    apply();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0000", req_rdy); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rstb = 1'b1;
    cycle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_lock_busy: got %b expected 1", busy); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_first_grant: got %0d expected 0", grant_id); end
  endtask

  task automatic test_rotation();
    logic [WIDTH-1:0] exp, got;
    int g;
    do_reset();
    rd_en = 1'b1;
    active = 4'b1111;
    apply();
    for (int n = 1; n <= 25; n++) begin
      cycle();
      n_checks++;
      if (busy !== ((n % 5) != 0)) begin
        n_fail++; $display("FAIL rot_busy cycle %0d: got %b expected %b", n, busy, (n % 5) != 0);
      end
      if ((n % 5) != 0) begin
        n_checks++;
        if (grant_id !== 2'(((n - 1) / 5) % 4)) begin
          n_fail++; $display("FAIL rot_grant cycle %0d: got %0d expected %0d", n, grant_id, ((n - 1) / 5) % 4);
        end
      end
    end
    active = '0;
    apply();
    cycle();
    cycle();
    n_checks++; if (wr_log.size() != 20) begin n_fail++; $display("FAIL rot_wr_count: got %0d expected 20", wr_log.size()); end
    n_checks++; if (rd_log.size() != 20) begin n_fail++; $display("FAIL rot_rd_count: got %0d expected 20", rd_log.size()); end
    for (int k = 0; k < 20; k++) begin
      g = k / 4;
      exp = {4'(g % 4), 4'((g == 4) ? 4 + (k % 4) : (k % 4))};
      got = (k < wr_log.size()) ? wr_log[k] : 8'hxx;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rot_wr_order[%0d]: got %h expected %h", k, got, exp); end
      got = (k < rd_log.size()) ? rd_log[k] : 8'hxx;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rot_rd_order[%0d]: got %h expected %h", k, got, exp); end
    end
  endtask

  task automatic test_early_last();
    logic [WIDTH-1:0] exp_q[4] = '{8'h20, 8'h21, 8'h30, 8'h22};
    logic [WIDTH-1:0] got;
    do_reset();
    rd_en = 1'b1;
    active[2] = 1'b1; rem[2] = 2; use_last[2] = 1'b1;
    apply();
    cycle();
    n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL last_grant2: got %0d expected 2", grant_id); end
    cycle();
    cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL last_busy_drop: got %b expected 0", busy); end
    // rr_ptr should now be 3: with 2 and 3 both valid, 3 wins, then wrap back to 2.
    active[2] = 1'b1; rem[2] = 1;
    active[3] = 1'b1; rem[3] = 1; use_last[3] = 1'b1;
    apply();
    cycle();
    n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL last_rr_ptr3: got %0d expected 3", grant_id); end
    cycle();
    cycle();
    n_checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL last_wrap_grant: got %0d/%b expected 2/1", grant_id, busy);
    end
    cycle();
    n_checks++; if (wr_log.size() != 4) begin n_fail++; $display("FAIL last_wr_count: got %0d expected 4", wr_log.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < wr_log.size()) ? wr_log[k] : 8'hxx;
      n_checks++; if (got !== exp_q[k]) begin n_fail++; $display("FAIL last_order[%0d]: got %h expected %h", k, got, exp_q[k]); end
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] got;
    do_reset();
    active[1] = 1'b1; rem[1] = 10;
    apply();
    for (int n = 0; n < 20; n++) cycle();
    n_checks++; if (wr_log.size() != 8) begin n_fail++; $display("FAIL full_writes: got %0d expected 8", wr_log.size()); end
    n_checks++; if (wr_full !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL full_state: got full %b busy %b expected 1/1", wr_full, busy);
    end
    n_checks++; if (req_rdy !== 4'b0000 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL full_blocked: got rdy %b wr_en %b expected 0000/0", req_rdy, wr_en);
    end
    rd_en = 1'b1;
    for (int n = 0; n < 20; n++) cycle();
    n_checks++; if (wr_log.size() != 10) begin n_fail++; $display("FAIL full_total_writes: got %0d expected 10", wr_log.size()); end
    n_checks++; if (rd_log.size() != 10) begin n_fail++; $display("FAIL full_total_reads: got %0d expected 10", rd_log.size()); end
    for (int k = 0; k < 10; k++) begin
      got = (k < rd_log.size()) ? rd_log[k] : 8'hxx;
      n_checks++; if (got !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL full_order[%0d]: got %h expected %h", k, got, 8'(8'h10 + k)); end
    end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL full_wr_en_while_full: got %0d expected 0", viol); end
  endtask

  task automatic test_valid_gap();
    logic [WIDTH-1:0] got;
    do_reset();
    rd_en = 1'b1;
    active = 4'b1111;
    apply();
    cycle();
    cycle();
    cycle();
    hold[0] = 1'b1;
    apply();
    for (int n = 0; n < 3; n++) begin
      cycle();
      n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL gap_hold[%0d]: got %0d/%b expected 0/1", n, grant_id, busy);
      end
      n_checks++; if (req_rdy !== 4'b0001 || wr_en !== 1'b0) begin
        n_fail++; $display("FAIL gap_rdy[%0d]: got rdy %b wr_en %b expected 0001/0", n, req_rdy, wr_en);
      end
    end
    hold[0] = 1'b0;
    apply();
    cycle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_resume_busy: got %b expected 1", busy); end
    cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_count_kept: got %b expected 0", busy); end
    cycle();
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL gap_next_grant: got %0d expected 1", grant_id); end
    n_checks++; if (wr_log.size() != 4) begin n_fail++; $display("FAIL gap_wr_count: got %0d expected 4", wr_log.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < wr_log.size()) ? wr_log[k] : 8'hxx;
      n_checks++; if (got !== 8'(k)) begin n_fail++; $display("FAIL gap_order[%0d]: got %h expected %h", k, got, 8'(k)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rd_en = 1'b1;
    active[2] = 1'b1; rem[2] = 1; use_last[2] = 1'b1;
    apply();
    cycle();
    cycle();
    active[1] = 1'b1;
    apply();
    cycle();
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_pre_grant: got %0d expected 1", grant_id); end
    cycle();
    cycle();
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wr_en: got %b expected 1", wr_en); end
    rstb = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0 || wr_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_async_wr: got %b/%h expected 0/00", wr_en, wr_data);
    end
    n_checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || req_rdy !== 4'b0000) begin
      n_fail++; $display("FAIL mid_async_state: got busy %b grant %0d rdy %b expected 0/0/0000", busy, grant_id, req_rdy);
    end
    active = 4'b1011;
    use_last = '0;
    for (int i = 0; i < N; i++) rem[i] = -1;
    apply();
    @(posedge clk);
    #1;
    rstb = 1'b1;
    cycle();
    n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_post_grant: got %0d/%b expected 0/1", grant_id, busy);
    end
    n_checks++; if (wr_log.size() != 3) begin n_fail++; $display("FAIL mid_wr_count: got %0d expected 3", wr_log.size()); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_early_last();
    test_full();
    test_valid_gap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares one `fifo_sram` write port among `N` requesters in a single clock domain (`SYNCH=1` instance). Each requester presents a valid/ready stream. The arbiter locks the write port to one requester for a burst, either until that requester's `last` beat or until `MAX_BURST` beats, whichever comes first. Writes are gated directly by `wr_full`, so the FIFO never sees `wr_en` while full.

## Interface
- `N`, 4: number of requesters, 2..16.
- `WIDTH`, 8: data width; must match the `fifo_sram` `WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.
- `clk`  in  1  clock for the arbiter and the shared FIFO.
- `rstb`  in  1  asynchronous, active-low reset.
- `req_val`  in  N  per-requester beat valid.
- `req_data`  in  N*WIDTH  per-requester data; lane i is `[i*WIDTH +: WIDTH]`.
- `req_last`  in  N  per-requester end-of-burst marker, qualified by valid.
- `req_rdy`  out  N  per-requester ready, combinational.
- `wr_en`  out  1  FIFO write enable, combinational.
- `wr_data`  out  WIDTH  FIFO write data.
- `wr_full`  in  1  FIFO full flag.
- `grant_id`  out  clog2(N)  current owner, registered.
- `busy`  out  1  high while in LOCK, registered.

## Operation
- State machine with two states, ARB and LOCK. Registers: `state`, `owner`, `rr_ptr`, `beat_cnt` (width clog2(MAX_BURST+1)).
- ARB:
  - No `req_rdy` is asserted.
  - If any `req_val` is high, pick the first set bit searching from `rr_ptr` upward, wrapping modulo N.
  - On the next edge: `owner` = winner, `beat_cnt` = 0, state = LOCK.
  - If no `req_val` is high, stay in ARB.
- LOCK:
  - `req_rdy[owner]` = ~`wr_full`; all other `req_rdy` bits are 0.
  - A beat is accepted when `req_val[owner]` & `req_rdy[owner]`.
  - `wr_en` = accept. `wr_data` = lane `owner` when `wr_en` is high, else 0.
  - Each accept increments `beat_cnt`.
  - End beat: an accepted beat with `req_last[owner]` = 1, or with `beat_cnt` == MAX_BURST-1.
  - On an end beat: state = ARB next edge, and `rr_ptr` = (owner+1) mod N.
- Owner drops valid mid-burst: the lock is held indefinitely with no timeout. Burst integrity takes priority over fairness.
- `wr_full` during LOCK: `req_rdy` and `wr_en` go low the same cycle; the lock is held and resumes when full deasserts.
- `req_last` with `req_val` low is ignored.
- Requests from non-owners are held off (ready = 0). No beat is ever dropped or duplicated.
- `rr_ptr` wrap: at owner = N-1, the pointer goes to 0.
- Reset, any time, including mid-burst:
  - state = ARB, `owner` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
  - `req_rdy` = 0, `wr_en` = 0, `wr_data` = 0, `grant_id` = 0, `busy` = 0.
  - The partial burst is abandoned; the FIFO is reset by the same `rstb`.
- `grant_id` mirrors `owner`. `busy` = (state == LOCK).

## Timing
- Arbitration bubble: 1 cycle. A request that sees ARB at edge k has its first possible accept in cycle k+1 (LOCK).
- Throughput: one beat per cycle while locked and not full. A back-to-back burst hand-off costs 1 idle cycle (ARB) between grants.
- `wr_en` and `req_rdy` are combinational from `state`, `owner`, `req_val` and `wr_full`. There is zero-cycle latency from accept to FIFO write.
- `wr_full` rising in the same cycle as a handshake blocks that beat: ready already sees full.
- Maximum wait for a continuously requesting source is (N-1)·(MAX_BURST+1) cycles, provided all owners eventually present `last` or full bursts and the FIFO drains.

## Test plan
- **Reset values.** Hold `rstb` low with `req_val` = 4'b1111 → all outputs 0. Release → the first edge enters LOCK with `grant_id` = 0 and `busy` = 1.
- **Round-robin rotation.** All 4 requesters continuously valid; each sends `data` = {id, beat}; `req_last` is never set; MAX_BURST = 4.
  - The FIFO receives 4 beats each from 0, 1, 2, 3, then 0 again.
  - There is exactly one ARB cycle between grants.
  - A downstream reader sees the same order.
- **Early last.** Requester 2 alone sends 2 beats with `last` on beat 2 → `busy` drops after beat 2, `rr_ptr` = 3, and the next grant to 2 still works via wrap.
- **FIFO full backpressure.** DEPTH = 8, with reads disabled, requester 1 streams 10 beats → exactly 8 writes occur and `wr_en` never coincides with `wr_full`. Enable reads → beats 9 and 10 are written in order with no loss.
- **Valid gap mid-burst.** The owner drops `req_val` for 3 cycles while other requesters are valid → no grant change, `beat_cnt` is preserved, and the burst resumes.
- **Reset mid-burst.** Assert `rstb` low after 2 beats of a 4-beat burst → `wr_en` goes low immediately and state returns to ARB with `rr_ptr` = 0. After release, requester 0 is granted first.
